// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared state, status and sizing definitions for the Maxnet controller
package maxnet_pkg;
    typedef enum logic [2:0] {IDLE, INIT, LOAD, SNAP, UPDATE, CHECK, DONE} state_t;
    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_WIN     = 2'b01;
    localparam logic [1:0] ST_ZERO    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;
    localparam int N_NEURONS = 4;
endpackage

// File: rtl/maxnet_controller.sv
// maxnet_controller: sequences load, snapshot and update sweeps until a winner, all-zero or timeout
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int MAX_ITER = 15,
    parameter int ITER_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cnt_co,
    input  logic              single_nz,
    input  logic              all_zero,
    output logic              cnt_init,
    output logic              cnt_en,
    output logic              ld_in,
    output logic              snap,
    output logic              ld_act,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [ITER_W-1:0] iter
);
    localparam logic [ITER_W-1:0] MAX_I = ITER_W'(MAX_ITER);

    state_t            state_q, state_d;
    logic [1:0]        status_q, status_d;
    logic [ITER_W-1:0] iter_q, iter_d, iter_inc;

    // state, outcome and sweep count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            status_q <= ST_NONE;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            iter_q   <= iter_d;
        end
    end

    // next state plus the registered outcome updates taken in INIT and CHECK
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        iter_d   = iter_q;
        iter_inc = (iter_q >= MAX_I) ? MAX_I : iter_q + ITER_W'(1);
        unique case (state_q)
            IDLE:    state_d = start ? INIT : IDLE;
            INIT: begin
                state_d  = LOAD;
                status_d = ST_NONE;
                iter_d   = '0;
            end
            LOAD:    state_d = cnt_co ? SNAP : LOAD;
            SNAP:    state_d = UPDATE;
            UPDATE:  state_d = cnt_co ? CHECK : UPDATE;
            CHECK: begin
                iter_d   = iter_inc;
                state_d  = (single_nz || all_zero || iter_inc == MAX_I) ? DONE : SNAP;
                status_d = single_nz ? ST_WIN : all_zero ? ST_ZERO :
                           (iter_inc == MAX_I) ? ST_TIMEOUT : status_q;
            end
            DONE:    state_d = start ? INIT : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign cnt_init = state_q == INIT;
    assign cnt_en   = state_q == LOAD || state_q == UPDATE;
    assign ld_in    = state_q == LOAD;
    assign snap     = state_q == SNAP;
    assign ld_act   = state_q == UPDATE;
    assign busy     = state_q != IDLE && state_q != DONE;
    assign done     = state_q == DONE;
    assign status   = status_q;
    assign iter     = iter_q;
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: directed vector bench with a modelled address counter per controller
module tb_maxnet_controller;
    logic clk = 0, rst = 1, start = 0, single_nz = 0, all_zero = 0, co_force = 0;
    logic ci0, ce0, li0, sn0, la0, bz0, dn0, ci1, ce1, li1, sn1, la1, bz1, dn1;
    logic [1:0] st0, st1, a0, a1;
    logic [3:0] it0, it1;
    int ncmp = 0, nerr = 0;

    typedef struct {
        int win, zero, fco, spc, sel;
        int lat, st, it, nin, nact, nsnap;
    } vec_t;
    vec_t tv[8];

    always #5 clk = ~clk;

    maxnet_controller #(.MAX_ITER(15), .ITER_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cnt_co(a0 == 2'd3 || co_force),
        .single_nz(single_nz), .all_zero(all_zero), .cnt_init(ci0), .cnt_en(ce0),
        .ld_in(li0), .snap(sn0), .ld_act(la0), .busy(bz0), .done(dn0), .status(st0), .iter(it0));

    maxnet_controller #(.MAX_ITER(3), .ITER_W(4)) dut3 (
        .clk(clk), .rst(rst), .start(start), .cnt_co(a1 == 2'd3),
        .single_nz(single_nz), .all_zero(all_zero), .cnt_init(ci1), .cnt_en(ce1),
        .ld_in(li1), .snap(sn1), .ld_act(la1), .busy(bz1), .done(dn1), .status(st1), .iter(it1));

    // address counters that sit beside each controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0 <= 2'd0;
            a1 <= 2'd0;
        end else begin
            a0 <= ci0 ? 2'd0 : ce0 ? a0 + 2'd1 : a0;
            a1 <= ci1 ? 2'd0 : ce1 ? a1 + 2'd1 : a1;
        end
    end

    function automatic logic hit(int k, int c);
        return k == 0 || c == 4 + 6 * k;
    endfunction

    task automatic chk(string name, int act, int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int lat0 = -1, lat1 = -1, nin = 0, nact = 0, nsnap = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int c = 0; c < 200 && (lat0 < 0 || lat1 < 0); c++) begin
            single_nz = hit(v.win, c);
            all_zero  = hit(v.zero, c);
            co_force  = v.fco != 0 && c == v.fco;
            start     = v.spc != 0 && c == v.spc;
            if (v.sel ? li1 : li0) nin++;
            if (v.sel ? la1 : la0) nact++;
            if (v.sel ? sn1 : sn0) nsnap++;
            if (dn0 && lat0 < 0) lat0 = c;
            if (dn1 && lat1 < 0) lat1 = c;
            @(negedge clk);
        end
        {single_nz, all_zero, co_force, start} = 4'b0;
        chk($sformatf("v%0d latency", idx), v.sel ? lat1 : lat0, v.lat);
        chk($sformatf("v%0d status", idx), v.sel ? int'(st1) : int'(st0), v.st);
        chk($sformatf("v%0d iter", idx), v.sel ? int'(it1) : int'(it0), v.it);
        chk($sformatf("v%0d ld_in cycles", idx), nin, v.nin);
        chk($sformatf("v%0d ld_act cycles", idx), nact, v.nact);
        chk($sformatf("v%0d snap pulses", idx), nsnap, v.nsnap);
    endtask

    initial begin
        tv[0] = '{1, 99, 0, 0, 0, 11, 1, 1, 4, 4, 1};
        tv[1] = '{3, 99, 0, 0, 0, 23, 1, 3, 4, 12, 3};
        tv[2] = '{99, 2, 0, 0, 0, 17, 2, 2, 4, 8, 2};
        tv[3] = '{1, 1, 0, 0, 0, 11, 1, 1, 4, 4, 1};
        tv[4] = '{99, 99, 0, 0, 1, 23, 3, 3, 4, 12, 3};
        tv[5] = '{99, 99, 0, 0, 0, 95, 3, 15, 4, 60, 15};
        tv[6] = '{1, 99, 0, 7, 0, 11, 1, 1, 4, 4, 1};
        tv[7] = '{0, 99, 2, 0, 0, 7, 1, 1, 2, 2, 1};
        repeat (3) @(negedge clk);
        chk("outputs in reset", int'({ci0, ce0, li0, sn0, la0, bz0, dn0, st0, it0}), 0);
        rst = 0;
        @(negedge clk);
        chk("outputs idle after reset", int'({ci0, ce0, li0, sn0, la0, bz0, dn0, st0, it0}), 0);
        for (int i = 0; i < 8; i++) run(tv[i], i);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int c = 0; c < 13; c++) @(negedge clk);
        chk("busy in second update", int'({bz0, la0}), 3);
        #2 rst = 1;
        #1 chk("async reset mid-run", int'({ci0, ce0, li0, sn0, la0, bz0, dn0, st0, it0}), 0);
        @(negedge clk) rst = 0;
        run(tv[1], 8);
        @(negedge clk) start = 1;
        @(posedge clk);
        #1;
        start = 0;
        chk("start in done: done", int'(dn0), 0);
        chk("start in done: init", int'({ci0, bz0}), 3);
        @(posedge clk);
        #1;
        chk("start in done: status cleared", int'(st0), 0);
        chk("start in done: iter cleared", int'(it0), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
